// File: rtl/adc_acq_pkg.sv
// Shared definitions for the three-channel ADC acquisition front-end:
// FSM encoding, frame geometry and the Iref offset-binary conversion.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LATCH,
        ST_QUIET
    } state_t;

    localparam int DATA_BITS  = 12;
    localparam int LEAD_ZEROS = 4;
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;

    // Offset binary to two's complement: mid-scale 0x800 maps to zero.
    function automatic logic signed [DATA_BITS-1:0] offset_to_twos(
        input logic [DATA_BITS-1:0] raw
    );
        return {~raw[DATA_BITS-1], raw[DATA_BITS-2:0]};
    endfunction

endpackage

// File: rtl/adc_acquisition_spi_sclk_gen.sv
// SPI serial-clock generator: CLK_DIV prescaler plus rising-edge counter.
// sclk idles high, starts with a falling edge and stays high after the frame.
module spi_sclk_gen
    import adc_acq_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic sclk,
    output logic sample_en,
    output logic frame_done
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [4:0] RISE_TOTAL = 5'(FRAME_BITS);

    logic [7:0] div_cnt;
    logic [4:0] rise_cnt;
    logic       tick;

    assign tick       = run && (div_cnt == DIV_LAST);
    assign sample_en  = tick && !sclk;
    // The half-period after the last rising edge is let run out before finishing.
    assign frame_done = tick && sclk && (rise_cnt == RISE_TOTAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk     <= 1'b1;
            div_cnt  <= 8'd0;
            rise_cnt <= 5'd0;
        end else if (start) begin
            sclk     <= 1'b0;
            div_cnt  <= 8'd0;
            rise_cnt <= 5'd0;
        end else if (run) begin
            if (tick) begin
                div_cnt <= 8'd0;
                if (!frame_done) begin
                    sclk <= ~sclk;
                end
                if (sample_en) begin
                    rise_cnt <= rise_cnt + 5'd1;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/adc_acquisition.sv
// Three-channel ADC acquisition: one trigger runs a shared-SPI frame and
// presents Vdc1/Vdc2/Iref as a coherent triple with a data_valid pulse.
module adc_acquisition
    import adc_acq_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int QUIET    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic                        miso_v1,
    input  logic                        miso_v2,
    input  logic                        miso_i,
    output logic                        cs_n,
    output logic                        sclk,
    output logic [DATA_BITS-1:0]        Vdc1,
    output logic [DATA_BITS-1:0]        Vdc2,
    output logic signed [DATA_BITS-1:0] Iref,
    output logic                        data_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);

    state_t               state;
    state_t               next_state;
    logic [7:0]           cnt;
    logic                 setup_done;
    logic                 shifting;
    logic                 sample_en;
    logic                 frame_done;
    logic [DATA_BITS-1:0] sr_v1;
    logic [DATA_BITS-1:0] sr_v2;
    logic [DATA_BITS-1:0] sr_i;

    assign setup_done = (state == ST_SETUP) && (cnt == SETUP_LAST);
    assign shifting   = (state == ST_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (setup_done),
        .run       (shifting),
        .sclk      (sclk),
        .sample_en (sample_en),
        .frame_done(frame_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (trigger)          next_state = ST_SETUP;
            ST_SETUP: if (setup_done)       next_state = ST_SHIFT;
            ST_SHIFT: if (frame_done)       next_state = ST_LATCH;
            ST_LATCH:                       next_state = ST_QUIET;
            ST_QUIET: if (cnt >= QUIET_LAST) next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
    end

    // The quiet count starts at LATCH, so cs_n is high for QUIET cycles before
    // the next trigger can be sampled in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 8'd0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if ((next_state != state) && (next_state == ST_SETUP || next_state == ST_LATCH)) begin
                cnt <= 8'd0;
            end else if (state == ST_SETUP || state == ST_LATCH || state == ST_QUIET) begin
                cnt <= cnt + 8'd1;
            end
            cs_n       <= !((state == ST_SETUP || state == ST_SHIFT) && next_state != ST_LATCH);
            busy       <= (state != ST_IDLE) && (next_state != ST_IDLE);
            overrun    <= overrun | (trigger && state != ST_IDLE);
            data_valid <= (state == ST_LATCH);
        end
    end

    // Only the last DATA_BITS samples survive; the leading zeros shift out the top.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            sr_v1 <= {sr_v1[DATA_BITS-2:0], miso_v1};
            sr_v2 <= {sr_v2[DATA_BITS-2:0], miso_v2};
            sr_i  <= {sr_i[DATA_BITS-2:0], miso_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Vdc1 <= '0;
            Vdc2 <= '0;
            Iref <= '0;
        end else if (state == ST_LATCH) begin
            Vdc1 <= sr_v1;
            Vdc2 <= sr_v2;
            Iref <= offset_to_twos(sr_i);
        end
    end

endmodule

// File: tb/tb_adc_acquisition.sv
// Directed bench for adc_acquisition: default instance plus a CLK_DIV=1,
// CS_SETUP=1 instance, each fed by serial ADC models driven on sclk falls.
module tb_adc_acquisition;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_a = 1'b0;
    logic        trig_f = 1'b0;
    logic [2:0]  miso_a;
    logic [2:0]  miso_f;
    logic        cs_n_a, sclk_a, dv_a, busy_a, ovr_a;
    logic        cs_n_f, sclk_f, dv_f, busy_f, ovr_f;
    logic [11:0] v1_a, v2_a, ir_a;
    logic [11:0] v1_f, v2_f, ir_f;
    logic [15:0] word [3];
    int          nfall_a = 0;
    int          nfall_f = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    adc_acquisition dut_a (
        .clk(clk), .rst(rst), .trigger(trig_a),
        .miso_v1(miso_a[0]), .miso_v2(miso_a[1]), .miso_i(miso_a[2]),
        .cs_n(cs_n_a), .sclk(sclk_a), .Vdc1(v1_a), .Vdc2(v2_a), .Iref(ir_a),
        .data_valid(dv_a), .busy(busy_a), .overrun(ovr_a)
    );

    adc_acquisition #(.CLK_DIV(1), .CS_SETUP(1), .QUIET(4)) dut_f (
        .clk(clk), .rst(rst), .trigger(trig_f),
        .miso_v1(miso_f[0]), .miso_v2(miso_f[1]), .miso_i(miso_f[2]),
        .cs_n(cs_n_f), .sclk(sclk_f), .Vdc1(v1_f), .Vdc2(v2_f), .Iref(ir_f),
        .data_valid(dv_f), .busy(busy_f), .overrun(ovr_f)
    );

    // ADC model: bit n of the frame appears after the n-th sclk falling edge.
    always @(negedge sclk_a or posedge cs_n_a)
        if (cs_n_a) nfall_a = 0; else nfall_a = nfall_a + 1;
    always @(negedge sclk_f or posedge cs_n_f)
        if (cs_n_f) nfall_f = 0; else nfall_f = nfall_f + 1;

    function automatic logic adc_bit(input logic [15:0] w, input int n);
        if (n < 1 || n > 16) return 1'b1;
        return w[16-n];
    endfunction

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            miso_a[c] = adc_bit(word[c], nfall_a);
            miso_f[c] = adc_bit(word[c], nfall_f);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic cs_of(input bit fast);   return fast ? cs_n_f : cs_n_a; endfunction
    function automatic logic sclk_of(input bit fast); return fast ? sclk_f : sclk_a; endfunction
    function automatic logic dv_of(input bit fast);   return fast ? dv_f : dv_a;     endfunction
    function automatic logic busy_of(input bit fast); return fast ? busy_f : busy_a; endfunction
    function automatic logic [11:0] res_of(input bit fast, input int idx);
        if (idx == 0) return fast ? v1_f : v1_a;
        if (idx == 1) return fast ? v2_f : v2_a;
        return fast ? ir_f : ir_a;
    endfunction

    task automatic run_frame(input bit fast, input logic [11:0] v1, input logic [11:0] v2,
                             input logic [11:0] iraw, input logic [11:0] exp_ir,
                             input logic [3:0] lead);
        int lat, cs_low, rises, first_r, last_r;
        bit got, prev;
        word[0] = {lead, v1};
        word[1] = {lead, v2};
        word[2] = {lead, iraw};
        @(negedge clk);
        if (fast) trig_f = 1'b1; else trig_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_f = 1'b0;
        trig_a = 1'b0;
        lat = 0; cs_low = 0; rises = 0; first_r = 0; last_r = 0; got = 1'b0;
        prev = sclk_of(fast);
        for (int k = 1; k <= 200 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!cs_of(fast)) cs_low++;
            if (sclk_of(fast) && !prev) begin
                rises++;
                if (rises == 1) first_r = k;
                last_r = k;
            end
            prev = sclk_of(fast);
            if (dv_of(fast)) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("latency", lat, fast ? 35 : 68);
        check("cs_low_cycles", cs_low, fast ? 33 : 66);
        check("sclk_rises", rises, 16);
        check("sclk_rise_span", last_r - first_r, fast ? 30 : 60);
        check("sclk_idle_high", {31'd0, sclk_of(fast)}, 1);
        check("vdc1", {20'd0, res_of(fast, 0)}, {20'd0, v1});
        check("vdc2", {20'd0, res_of(fast, 1)}, {20'd0, v2});
        check("iref", {20'd0, res_of(fast, 2)}, {20'd0, exp_ir});
        @(posedge clk);
        @(negedge clk);
        check("dv_width", {31'd0, dv_of(fast)}, 0);
        for (int k = 0; k < 50 && busy_of(fast); k++) @(negedge clk);
        check("busy_release", {31'd0, busy_of(fast)}, 0);
    endtask

    initial begin
        int dv_cnt, dv1, dv2;
        logic [11:0] r1, r2, r3;
        word[0] = 16'h0;
        word[1] = 16'h0;
        word[2] = 16'h0;

        #1 rst = 1'b0;
        #1;
        check("rst_cs_n", {31'd0, cs_n_a}, 1);
        check("rst_sclk", {31'd0, sclk_a}, 1);
        check("rst_vdc1", {20'd0, v1_a}, 0);
        check("rst_iref", {20'd0, ir_a}, 0);
        check("rst_dv", {31'd0, dv_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_overrun", {31'd0, ovr_a}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(1'b0, 12'h3FF, 12'h800, 12'h800, 12'h000, 4'h0);
        run_frame(1'b0, 12'h001, 12'hFFF, 12'hFFF, 12'h7FF, 4'h0);
        run_frame(1'b0, 12'hFFE, 12'h000, 12'h000, 12'h800, 4'h0);
        run_frame(1'b0, 12'h555, 12'hAAA, 12'h801, 12'h001, 4'h0);
        // Alternating pattern with a non-zero lead nibble that must be discarded.
        run_frame(1'b0, 12'hA5A, 12'hA5A, 12'hA5A, 12'h25A, 4'hF);

        // Overrun: triggers at 10 and 71 are ignored, the one at 72 starts a frame.
        check("ovr_before", {31'd0, ovr_a}, 0);
        word[0] = 16'h0123;
        word[1] = 16'h0456;
        word[2] = 16'h0789;
        @(negedge clk);
        trig_a = 1'b1;
        @(posedge clk);
        dv_cnt = 0; dv1 = 0; dv2 = 0;
        for (int e = 1; e <= 150; e++) begin
            @(negedge clk);
            trig_a = (e == 10 || e == 71 || e == 72);
            if (e == 70) begin
                word[0] = 16'h0ABC;
                word[1] = 16'h0DEF;
                word[2] = 16'h0000;
            end
            @(posedge clk);
            #1;
            if (e == 70) check("busy_in_quiet", {31'd0, busy_a}, 1);
            if (e == 71) check("busy_after_quiet", {31'd0, busy_a}, 0);
            if (dv_a) begin
                dv_cnt++;
                if (dv_cnt == 1) begin
                    dv1 = e;
                    check("ovr_f1_vdc1", {20'd0, v1_a}, 32'h123);
                    check("ovr_f1_vdc2", {20'd0, v2_a}, 32'h456);
                    check("ovr_f1_iref", {20'd0, ir_a}, 32'hF89);
                end else if (dv_cnt == 2) begin
                    dv2 = e;
                    check("ovr_f2_vdc1", {20'd0, v1_a}, 32'hABC);
                    check("ovr_f2_vdc2", {20'd0, v2_a}, 32'hDEF);
                    check("ovr_f2_iref", {20'd0, ir_a}, 32'h800);
                end
            end
        end
        @(negedge clk);
        trig_a = 1'b0;
        check("ovr_dv_count", dv_cnt, 2);
        check("ovr_dv1_cycle", dv1, 68);
        check("ovr_dv2_cycle", dv2, 140);
        check("ovr_flag", {31'd0, ovr_a}, 1);
        repeat (20) @(negedge clk);
        check("ovr_sticky", {31'd0, ovr_a}, 1);

        // Reset in the middle of a frame, while sclk is low.
        word[0] = 16'h0321;
        word[1] = 16'h0654;
        word[2] = 16'h0987;
        @(negedge clk);
        trig_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_a = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        check("mid_sclk_low", {31'd0, sclk_a}, 0);
        check("mid_cs_low", {31'd0, cs_n_a}, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_cs_n", {31'd0, cs_n_a}, 1);
        check("arst_sclk", {31'd0, sclk_a}, 1);
        check("arst_vdc1", {20'd0, v1_a}, 0);
        check("arst_vdc2", {20'd0, v2_a}, 0);
        check("arst_iref", {20'd0, ir_a}, 0);
        check("arst_busy", {31'd0, busy_a}, 0);
        check("arst_overrun", {31'd0, ovr_a}, 0);
        dv_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (dv_a) dv_cnt++;
        end
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dv_a || !cs_n_a) dv_cnt++;
        end
        check("arst_no_frame", dv_cnt, 0);
        run_frame(1'b0, 12'h321, 12'h654, 12'h987, 12'h187, 4'h0);

        // Fast instance: sclk at half the system clock, then random frames.
        run_frame(1'b1, 12'h3FF, 12'h800, 12'h800, 12'h000, 4'h0);
        run_frame(1'b1, 12'hA5A, 12'hA5A, 12'hA5A, 12'h25A, 4'h0);
        for (int n = 0; n < 100; n++) begin
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            r3 = 12'($urandom_range(0, 4095));
            run_frame(1'b1, r1, r2, r3, {~r3[11], r3[10:0]}, 4'($urandom_range(0, 15)));
            repeat (25) @(negedge clk);
        end
        check("fast_overrun", {31'd0, ovr_f}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
